// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants, FSM state encoding and layer-mode encoding
// for the convolution datapath source side.
package bnn_pkg;

    localparam int IMG_PIX_L0 = 784;  // 28x28 input, layer 0
    localparam int IMG_PIX_L1 = 144;  // 12x12 input, layer 1
    localparam int KBITS      = 25;   // 5x5 binary kernel

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WGT   = 3'd1,
        ST_STRM  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } feeder_state_e;

    typedef enum logic {
        MODE_L0 = 1'b0,
        MODE_L1 = 1'b1
    } layer_mode_e;

    function automatic int unsigned layer_pixels(input layer_mode_e mode);
        return (mode == MODE_L1) ? IMG_PIX_L1 : IMG_PIX_L0;
    endfunction

endpackage

// File: rtl/conv_feeder_if.sv
// conv_feeder_if: feeder <-> convolution block link (kernel load, pixel
// stream with din_ready handshake, and completion).
interface conv_feeder_if #(
    parameter int PIX_W = 32
);
    logic             start;
    logic             weight_en;
    logic             weight;
    logic             state;
    logic [PIX_W-1:0] din;
    logic             din_ready;
    logic             conv_done;

    modport master (
        output start, weight_en, weight, state, din,
        input  din_ready, conv_done
    );

    modport slave (
        input  start, weight_en, weight, state, din,
        output din_ready, conv_done
    );
endinterface

// File: rtl/feeder_buf.sv
// feeder_buf: feature-map store, one synchronous write port and one
// combinational read port; the parent registers the read data into din.
module feeder_buf
    import bnn_pkg::*;
#(
    parameter int PIX_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = IMG_PIX_L0
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [PIX_W-1:0]  rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; it is filled before every run, and a
    // reset port would stop it from mapping onto plain storage.
    always_ff @(posedge clk) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/conv_feeder.sv
// conv_feeder: holds one feature map and a 5x5 binary kernel and feeds them to the conv block.
// Optional DRAIN watchdog with a sticky timeout flag: define CONV_FEEDER_TIMEOUT_EN.
module conv_feeder
    import bnn_pkg::*;
#(
    parameter int PIX_W  = 32,
    parameter int ADDR_W = 10,
    parameter int KBITS  = bnn_pkg::KBITS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [KBITS-1:0]  kernel_in,
    input  logic              mode_in,
    input  logic              launch,
    output logic              busy,
    output logic              finished,
    conv_feeder_if.master     cif
`ifdef CONV_FEEDER_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int WCNT_W = $clog2(KBITS);

    feeder_state_e     fsm_q;
    logic [KBITS-1:0]  kern_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] rp_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] last_q;
    logic [PIX_W-1:0]  din_q;
    logic              start_q;
    logic              weight_en_q;
    logic              weight_q;
    logic              mode_q;
    logic              busy_q;
    logic              finished_q;
`ifdef CONV_FEEDER_TIMEOUT_EN
    logic [11:0]       wd_q;
    logic              timeout_q;
`endif

    logic              buf_we;
    logic [ADDR_W-1:0] buf_raddr;
    logic [PIX_W-1:0]  buf_rdata;

    assign buf_we    = wr_en && !busy_q;
    // In IDLE the read port looks at pixel 0 so launch can preload din.
    assign buf_raddr = (fsm_q == ST_IDLE) ? '0 : rp_q;

    feeder_buf #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (IMG_PIX_L0)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every branch below reads the values from before this clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q       <= ST_IDLE;
            kern_q      <= '0;
            wcnt_q      <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            din_q       <= '0;
            start_q     <= 1'b0;
            weight_en_q <= 1'b0;
            weight_q    <= 1'b0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
`ifdef CONV_FEEDER_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            finished_q <= 1'b0;
            unique case (fsm_q)
                ST_IDLE: begin
                    if (launch) begin
                        fsm_q       <= ST_WGT;
                        weight_q    <= kernel_in[KBITS-1];
                        kern_q      <= {kernel_in[KBITS-2:0], 1'b0};
                        wcnt_q      <= '0;
                        start_q     <= 1'b1;
                        weight_en_q <= 1'b1;
                        busy_q      <= 1'b1;
                        mode_q      <= mode_in;
                        last_q      <= ADDR_W'(layer_pixels(layer_mode_e'(mode_in)) - 1);
                        din_q       <= buf_rdata;
                        rp_q        <= ADDR_W'(1);
                        cnt_q       <= '0;
                    end
                end
                ST_WGT: begin
                    if (wcnt_q == WCNT_W'(KBITS - 1)) begin
                        fsm_q       <= ST_STRM;
                        weight_en_q <= 1'b0;
                        weight_q    <= 1'b0;
                    end else begin
                        wcnt_q   <= wcnt_q + WCNT_W'(1);
                        weight_q <= kern_q[KBITS-1];
                        kern_q   <= {kern_q[KBITS-2:0], 1'b0};
                    end
                end
                ST_STRM: begin
                    if (cif.din_ready) begin
                        if (cnt_q == last_q) begin
                            fsm_q <= ST_DRAIN;
                            din_q <= '0;
`ifdef CONV_FEEDER_TIMEOUT_EN
                            wd_q  <= 12'd1;
`endif
                        end else begin
                            din_q <= buf_rdata;
                            rp_q  <= rp_q + ADDR_W'(1);
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
`ifdef CONV_FEEDER_TIMEOUT_EN
                    if (cif.conv_done || (wd_q == '1)) begin
                        fsm_q      <= ST_FIN;
                        start_q    <= 1'b0;
                        finished_q <= 1'b1;
                        if (!cif.conv_done) timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 12'd1;
                    end
`else
                    if (cif.conv_done) begin
                        fsm_q      <= ST_FIN;
                        start_q    <= 1'b0;
                        finished_q <= 1'b1;
                    end
`endif
                end
                ST_FIN: begin
                    fsm_q  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign cif.start     = start_q;
    assign cif.weight_en = weight_en_q;
    assign cif.weight    = weight_q;
    assign cif.state     = mode_q;
    assign cif.din       = din_q;
    assign busy          = busy_q;
    assign finished      = finished_q;
`ifdef CONV_FEEDER_TIMEOUT_EN
    assign timeout       = timeout_q;
`endif

endmodule
